iir_capture_buf: RTL and testbench
==================================

Name: iir_capture_buf

Overview:
- Hardware sink for the IIR filter output stream: records a block of DEPTH consecutive 16-bit output samples into on-chip RAM, then streams them back out over a valid/ready read port.
- Sits after the IIR instance. Replaces file-based output capture, so filter response can be read back on silicon or by a host bus bridge.
- Arm/trigger control plus a streaming readout make it the consumer end of the filter's sample interface.

Parameters:
- DATA_W, 16, sample width; matches the filter output y.
- DEPTH, 256, samples per capture block; must be a power of 2, ≥ 4.
- ADDR_W, $clog2(DEPTH), buffer address and count width.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- y_in  in  DATA_W  filter output sample, two's complement.
- y_valid  in  1  y_in is valid this cycle; no back-pressure toward the filter.
- arm  in  1  one-cycle pulse: start a new capture.
- abort  in  1  one-cycle pulse: return to IDLE from any state.
- rd_start  in  1  one-cycle pulse: begin readout (honoured only in DONE).
- rd_data  out  DATA_W  readout sample.
- rd_valid  out  1  rd_data valid.
- rd_ready  in  1  consumer accepts rd_data when rd_valid && rd_ready.
- rd_last  out  1  high with the final readout sample (index DEPTH-1).
- busy  out  1  high in ARMED, CAPTURE or READOUT.
- done  out  1  high in DONE.
- wr_count  out  ADDR_W+1  samples stored in the current block, range 0..DEPTH.

Behaviour:
- Reset: state=IDLE; wr_count=0; rd_valid=0, rd_last=0, rd_data=0; busy=0, done=0. RAM contents are not cleared.
- States and transitions:
  - IDLE: arm → CAPTURE, or → ARMED when THRESHOLD_TRIG_EN is defined. On entering, wr_count=0.
  - CAPTURE: each cycle with y_valid, write y_in to RAM[wr_count] and increment wr_count. The sample that makes wr_count==DEPTH moves the block to DONE on the same edge. Samples with y_valid=0 are not counted.
  - DONE: done=1. rd_start → READOUT with read index 0. arm → fresh capture; the old block is discarded and wr_count=0. If arm and rd_start arrive together, arm wins.
  - READOUT: samples are presented in write order, index 0..DEPTH-1.
    - rd_data and rd_valid are registered.
    - First rd_valid is asserted no later than 2 cycles after rd_start.
    - While rd_ready=1, one sample per cycle is transferred: a synchronous-read RAM with a prefetch/skid register, no bubbles.
    - rd_data holds stable while rd_valid && !rd_ready.
    - rd_last is asserted with index DEPTH-1. Its transfer → DONE, with the buffer retained, so the block can be re-read.
- arm in CAPTURE or READOUT is ignored.
- abort in any state → IDLE next edge. rd_valid drops the same edge. wr_count is cleared on IDLE entry.
- rst during any state: identical to reset, taking effect at the next edge.
- y_valid outside CAPTURE is ignored and never written.
- No arithmetic on sample data; samples are stored bit-exact.

Optional Feature:
- Macro: IIR_CAPTURE_THRESHOLD_TRIG_EN.
- Defined:
  - Adds port trig_level in DATA_W, unsigned magnitude, and state ARMED.
  - In ARMED, a y_valid sample with |y_in| ≥ trig_level is the trigger: it is written as index 0 and the state moves to CAPTURE with wr_count=1.
  - |−32768| is taken as 32768; no overflow on the magnitude.
  - Samples before the trigger are dropped.
  - abort works in ARMED.
- Undefined: no trig_level port; arm goes directly to CAPTURE.

Decomposition:
- Shared package iir_pkg:
  - state encoding (IDLE, ARMED, CAPTURE, DONE, READOUT);
  - DATA_W default constant;
  - sample typedef, signed logic [DATA_W-1:0].
- One natural sub-module: iir_cap_ram, a simple dual-port RAM with one write port, one synchronous read port and 1-cycle read latency. The FSM, counters and readout skid logic stay in the top module.

Test Plan:
- Basic capture and readout: reset; arm; drive y_in=0..255 with y_valid every cycle → done=1 exactly 256 cycles after the first valid sample; wr_count=256; rd_start with rd_ready=1 gives rd_data 0..255 on consecutive cycles, rd_last on 255.
- Gapped input: y_valid on alternate cycles, values 1000+i → buffer holds 1000..1255 with no duplicates or holes.
- Back-pressure: during readout, toggle rd_ready randomly (and hold it low for 5 cycles at index 100) → rd_data stays at 100 while stalled; the full sequence arrives in order, exactly once.
- Re-read and re-arm:
  - a second rd_start after the first readout → identical 256-sample sequence;
  - arm and rd_start in the same DONE cycle → capture starts, rd_valid stays 0.
- Abort and reset mid-operation:
  - abort at wr_count=37 → IDLE, busy=0, wr_count=0;
  - rst asserted mid-readout → rd_valid=0 next edge and all outputs at reset values.
- With IIR_CAPTURE_THRESHOLD_TRIG_EN, trig_level=16'd500, input ramp −600,−599,…:
  - −600 triggers immediately and is stored as index 0;
  - with an input 0..499 followed by 500, the block starts at 500.

Source files
------------

// File: rtl/iir_pkg.sv
// rtl/iir_pkg.sv - shared state encoding, sample width and sample type for the IIR capture buffer
package iir_pkg;

    // Width of one filter output sample.
    localparam int IIR_DATA_W = 16;

    // One filter output sample, two's complement.
    typedef logic signed [IIR_DATA_W-1:0] sample_t;

    // Capture buffer control states.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARMED   = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_DONE    = 3'd3,
        ST_READOUT = 3'd4
    } cap_state_t;

endpackage

// File: rtl/iir_cap_ram.sv
// rtl/iir_cap_ram.sv - simple dual-port sample RAM, one write port, one synchronous read port
module iir_cap_ram
    import iir_pkg::*;
#(
    parameter int DATA_W = IIR_DATA_W,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [0:(2**ADDR_W)-1];

    // Write port: store the sample bit-exact.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Read port: one cycle latency, output holds when no read is issued.
    always_ff @(posedge clk) begin
        if (i_re) begin
            o_rdata <= r_mem[i_raddr];
        end
    end

endmodule

// File: rtl/iir_capture_buf.sv
// rtl/iir_capture_buf.sv - IIR output capture buffer with streaming readout; option IIR_CAPTURE_THRESHOLD_TRIG_EN
module iir_capture_buf
    import iir_pkg::*;
#(
    parameter int DATA_W = IIR_DATA_W,
    parameter int DEPTH  = 256,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] y_in,
    input  logic              y_valid,
    input  logic              arm,
    input  logic              abort,
    input  logic              rd_start,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic              rd_last,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   wr_count
`ifdef IIR_CAPTURE_THRESHOLD_TRIG_EN
    ,
    input  logic [DATA_W-1:0] trig_level
`endif
);

    localparam logic [ADDR_W:0] L_DEPTH = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] L_LAST  = (ADDR_W+1)'(DEPTH - 1);
    localparam logic [ADDR_W:0] L_ONE   = (ADDR_W+1)'(1);

`ifdef IIR_CAPTURE_THRESHOLD_TRIG_EN
    localparam cap_state_t L_ARM_STATE = ST_ARMED;
`else
    localparam cap_state_t L_ARM_STATE = ST_CAPTURE;
`endif

    cap_state_t        r_state;
    logic [ADDR_W:0]   r_fetch_idx;   // next index to fetch from RAM
    logic              r_pend;        // RAM output holds a fetched sample this cycle
    logic              r_pend_last;
    logic [DATA_W-1:0] r_skid_data;   // catches the in-flight sample when the consumer stalls
    logic              r_skid_valid;
    logic              r_skid_last;

    logic              w_trig;
    logic              w_we;
    logic              w_start;
    logic              w_issue;
    logic              w_re;
    logic [ADDR_W-1:0] w_raddr;
    logic [DATA_W-1:0] w_ram_q;
    logic [1:0]        w_slots_used;
    logic              w_out_free;

`ifdef IIR_CAPTURE_THRESHOLD_TRIG_EN
    // Magnitude is one bit wider so the most negative sample does not wrap.
    logic [DATA_W:0] w_mag;
    assign w_mag  = y_in[DATA_W-1] ? ({1'b0, ~y_in} + (DATA_W+1)'(1)) : {1'b0, y_in};
    assign w_trig = (r_state == ST_ARMED) && y_valid && (w_mag >= {1'b0, trig_level});
`else
    assign w_trig = 1'b0;
`endif

    // The trigger sample lands at index 0 because wr_count is still zero in ARMED.
    assign w_we = !abort && (((r_state == ST_CAPTURE) && y_valid) || w_trig);

    // Readout slots still occupied after this cycle's transfer; fetch only while one is free.
    assign w_out_free   = !rd_valid || rd_ready;
    assign w_slots_used = {1'b0, rd_valid & ~rd_ready} + {1'b0, r_skid_valid} + {1'b0, r_pend};
    assign w_start      = (r_state == ST_DONE) && rd_start && !arm && !abort;
    assign w_issue      = (r_state == ST_READOUT) && !abort &&
                          (r_fetch_idx != L_DEPTH) && (w_slots_used < 2'd2);
    assign w_re         = w_start || w_issue;
    assign w_raddr      = w_start ? '0 : r_fetch_idx[ADDR_W-1:0];

    iir_cap_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (wr_count[ADDR_W-1:0]),
        .i_wdata (y_in),
        .i_re    (w_re),
        .i_raddr (w_raddr),
        .o_rdata (w_ram_q)
    );

    // Control FSM, write counter and readout prefetch/skid pipeline.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            wr_count     <= '0;
            rd_data      <= '0;
            rd_valid     <= 1'b0;
            rd_last      <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            r_fetch_idx  <= '0;
            r_pend       <= 1'b0;
            r_pend_last  <= 1'b0;
            r_skid_data  <= '0;
            r_skid_valid <= 1'b0;
            r_skid_last  <= 1'b0;
        end else if (abort) begin
            r_state      <= ST_IDLE;
            wr_count     <= '0;
            rd_valid     <= 1'b0;
            rd_last      <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            r_pend       <= 1'b0;
            r_skid_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (arm) begin
                        r_state  <= L_ARM_STATE;
                        wr_count <= '0;
                        busy     <= 1'b1;
                    end
                end
                ST_ARMED: begin
                    if (w_trig) begin
                        r_state  <= ST_CAPTURE;
                        wr_count <= L_ONE;
                    end
                end
                ST_CAPTURE: begin
                    if (y_valid) begin
                        wr_count <= wr_count + L_ONE;
                        if (wr_count == L_LAST) begin
                            r_state <= ST_DONE;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    if (arm) begin
                        r_state  <= L_ARM_STATE;
                        wr_count <= '0;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                    end else if (rd_start) begin
                        // Index 0 is fetched on this edge, so the next fetch is index 1.
                        r_state      <= ST_READOUT;
                        busy         <= 1'b1;
                        done         <= 1'b0;
                        r_fetch_idx  <= L_ONE;
                        r_pend       <= 1'b1;
                        r_pend_last  <= 1'b0;
                        r_skid_valid <= 1'b0;
                    end
                end
                ST_READOUT: begin
                    if (rd_valid && rd_ready && rd_last) begin
                        // Final sample accepted; the block stays in RAM for a re-read.
                        r_state      <= ST_DONE;
                        busy         <= 1'b0;
                        done         <= 1'b1;
                        rd_valid     <= 1'b0;
                        rd_last      <= 1'b0;
                        r_pend       <= 1'b0;
                        r_skid_valid <= 1'b0;
                    end else begin
                        if (w_issue) begin
                            r_pend      <= 1'b1;
                            r_pend_last <= (r_fetch_idx == L_LAST);
                            r_fetch_idx <= r_fetch_idx + L_ONE;
                        end else begin
                            r_pend <= 1'b0;
                        end
                        if (w_out_free) begin
                            if (r_skid_valid) begin
                                rd_data      <= r_skid_data;
                                rd_last      <= r_skid_last;
                                rd_valid     <= 1'b1;
                                r_skid_valid <= r_pend;
                                r_skid_data  <= w_ram_q;
                                r_skid_last  <= r_pend_last;
                            end else if (r_pend) begin
                                rd_data  <= w_ram_q;
                                rd_last  <= r_pend_last;
                                rd_valid <= 1'b1;
                            end else begin
                                rd_valid <= 1'b0;
                                rd_last  <= 1'b0;
                            end
                        end else if (r_pend) begin
                            r_skid_valid <= 1'b1;
                            r_skid_data  <= w_ram_q;
                            r_skid_last  <= r_pend_last;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iir_capture_buf.sv
// tb/tb_iir_capture_buf.sv - self-checking bench for iir_capture_buf: table vectors, directed corners, random capture/readout
module tb_iir_capture_buf;

    localparam int DW    = 16;
    localparam int DEPTH = 256;
    localparam int AW    = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] y_in;
    logic          y_valid;
    logic          arm;
    logic          abort;
    logic          rd_start;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          rd_ready;
    logic          rd_last;
    logic          busy;
    logic          done;
    logic [AW:0]   wr_count;
`ifdef IIR_CAPTURE_THRESHOLD_TRIG_EN
    logic [DW-1:0] trig_level;
`endif

    always #5 clk = ~clk;

    iir_capture_buf #(
        .DATA_W (DW),
        .DEPTH  (DEPTH),
        .ADDR_W (AW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .y_in       (y_in),
        .y_valid    (y_valid),
        .arm        (arm),
        .abort      (abort),
        .rd_start   (rd_start),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .rd_ready   (rd_ready),
        .rd_last    (rd_last),
        .busy       (busy),
        .done       (done),
        .wr_count   (wr_count)
`ifdef IIR_CAPTURE_THRESHOLD_TRIG_EN
        ,
        .trig_level (trig_level)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: the block is the first DEPTH valid samples after arm,
    // starting at the first one whose magnitude reaches the threshold.
    int exp_q[$];
    bit m_active  = 1'b0;
    bit m_trig    = 1'b0;
    int m_level   = 0;

    typedef struct {
        int arm;
        int abort;
        int rd_start;
        int n_samp;
        int e_busy;
        int e_done;
        int e_rdv;
        int e_wc;
    } row_t;

    row_t tbl [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic send(input logic valid, input logic [DW-1:0] val);
        int s;
        y_valid = valid;
        y_in    = val;
        if (m_active && valid && exp_q.size() < DEPTH) begin
            s = int'($signed(val));
            if (s < 0) s = -s;
            if (m_trig || s >= m_level) begin
                m_trig = 1'b1;
                exp_q.push_back(int'(val));
                if (exp_q.size() == DEPTH) m_active = 1'b0;
            end
        end
        tick();
        y_valid = 1'b0;
    endtask

    task automatic start_capture();
        arm = 1'b1;
        tick();
        arm = 1'b0;
        exp_q.delete();
        m_trig   = 1'b0;
        m_active = 1'b1;
    endtask

    task automatic readout(input bit rnd, input int stall_idx);
        int idx     = 0;
        int cyc     = 0;
        int first   = -1;
        int bubbles = 0;
        int hold    = 0;
        logic rdy;
        rd_ready = 1'b1;
        rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
        while (idx < DEPTH && cyc < 5000) begin
            rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (rd_valid && idx == stall_idx && hold < 5) begin
                rdy = 1'b0;
                hold++;
            end
            rd_ready = rdy;
            if (rd_valid) begin
                if (first < 0) first = cyc;
                check("rd_data", 32'(rd_data), 32'(exp_q[idx] & 'hFFFF));
                check("rd_last", 32'(rd_last), 32'(idx == DEPTH - 1));
                if (rdy) idx++;
            end else if (first >= 0) begin
                bubbles++;
            end
            tick();
            cyc++;
        end
        rd_ready = 1'b1;
        check("rd_count", 32'(idx), 32'(DEPTH));
        check("rd_latency_le2", 32'(first >= 0 && first <= 1), 32'd1);
        if (!rnd) check("rd_bubbles", 32'(bubbles), 32'd0);
        check("rd_end_valid", 32'(rd_valid), 32'd0);
        check("rd_end_done", 32'(done), 32'd1);
    endtask

    task automatic fill_block(input int gap, input int base, input bit rnd);
        int k = 0;
        int i = 0;
        while (m_active && k < 4000) begin
            if (rnd) begin
                send(1'($urandom_range(0, 2) != 0), 16'($urandom));
            end else if (gap != 0 && (k % 2) == 1) begin
                send(1'b0, 16'hDEAD);
            end else begin
                send(1'b1, 16'(base + i));
                i++;
            end
            k++;
        end
        check("fill_done", 32'(done), 32'd1);
        check("fill_wr_count", 32'(wr_count), 32'(DEPTH));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not reach its end, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        rst      = 1'b1;
        arm      = 1'b0;
        abort    = 1'b0;
        rd_start = 1'b0;
        rd_ready = 1'b1;
        y_valid  = 1'b0;
        y_in     = '0;
`ifdef IIR_CAPTURE_THRESHOLD_TRIG_EN
        trig_level = '0;
`endif
        m_level = 0;
        tick();
        tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_rd_last", 32'(rd_last), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'd0);
        check("rst_wr_count", 32'(wr_count), 32'd0);
        rst = 1'b0;
        tick();

        // Control table: pulse, then n valid samples, then expected status.
        tbl[0]  = '{0, 0, 0, 0,   0, 0, 0, 0};
        tbl[1]  = '{1, 0, 0, 0,   1, 0, 0, 0};
        tbl[2]  = '{0, 0, 0, 10,  1, 0, 0, 10};
        tbl[3]  = '{1, 0, 0, 0,   1, 0, 0, 10};
        tbl[4]  = '{0, 1, 0, 0,   0, 0, 0, 0};
        tbl[5]  = '{0, 0, 1, 0,   0, 0, 0, 0};
        tbl[6]  = '{1, 0, 0, 0,   1, 0, 0, 0};
        tbl[7]  = '{0, 0, 0, 256, 0, 1, 0, 256};
        tbl[8]  = '{0, 0, 0, 5,   0, 1, 0, 256};
        tbl[9]  = '{1, 0, 1, 0,   1, 0, 0, 0};
        tbl[10] = '{0, 0, 0, 3,   1, 0, 0, 3};
        tbl[11] = '{0, 1, 0, 0,   0, 0, 0, 0};
        for (int r = 0; r < 12; r++) begin
            arm      = (tbl[r].arm != 0);
            abort    = (tbl[r].abort != 0);
            rd_start = (tbl[r].rd_start != 0);
            tick();
            arm      = 1'b0;
            abort    = 1'b0;
            rd_start = 1'b0;
            for (int n = 0; n < tbl[r].n_samp; n++) send(1'b1, 16'(n + 7));
            check($sformatf("tbl%0d_busy", r), 32'(busy), 32'(tbl[r].e_busy));
            check($sformatf("tbl%0d_done", r), 32'(done), 32'(tbl[r].e_done));
            check($sformatf("tbl%0d_rd_valid", r), 32'(rd_valid), 32'(tbl[r].e_rdv));
            check($sformatf("tbl%0d_wr_count", r), 32'(wr_count), 32'(tbl[r].e_wc));
        end

        // Basic ramp: done exactly on the 256th valid sample.
        start_capture();
        for (int i = 0; i < DEPTH; i++) begin
            send(1'b1, 16'(i));
            if (i == DEPTH - 2) check("basic_done_early", 32'(done), 32'd0);
        end
        check("basic_done", 32'(done), 32'd1);
        check("basic_busy", 32'(busy), 32'd0);
        check("basic_wr_count", 32'(wr_count), 32'(DEPTH));
        readout(1'b0, -1);

        // Re-read of the same block.
        readout(1'b0, -1);

        // Gapped input, values 1000+i on alternate cycles.
        start_capture();
        fill_block(1, 1000, 1'b0);
        readout(1'b0, -1);

        // Back-pressure with a 5-cycle stall at index 100.
        readout(1'b1, 100);

        // Random data, random gaps, random back-pressure.
        for (int b = 0; b < 3; b++) begin
            start_capture();
            fill_block(0, 0, 1'b1);
            readout(1'b1, $urandom_range(0, DEPTH - 1));
        end

        // Abort mid-capture at wr_count = 37.
        start_capture();
        for (int i = 0; i < 37; i++) send(1'b1, 16'(i));
        check("abort_pre_wc", 32'(wr_count), 32'd37);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        m_active = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_wc", 32'(wr_count), 32'd0);

        // Reset mid-readout.
        start_capture();
        fill_block(0, 300, 1'b0);
        rd_ready = 1'b1;
        rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        check("mid_rd_valid", 32'(rd_valid), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rstrd_rd_valid", 32'(rd_valid), 32'd0);
        check("rstrd_rd_last", 32'(rd_last), 32'd0);
        check("rstrd_rd_data", 32'(rd_data), 32'd0);
        check("rstrd_busy", 32'(busy), 32'd0);
        check("rstrd_done", 32'(done), 32'd0);
        check("rstrd_wc", 32'(wr_count), 32'd0);

`ifdef IIR_CAPTURE_THRESHOLD_TRIG_EN
        // Ramp from -600: the first sample already reaches the threshold.
        trig_level = 16'd500;
        m_level    = 500;
        start_capture();
        send(1'b1, 16'(-600));
        check("trig_neg_wc", 32'(wr_count), 32'd1);
        for (int v = -599; m_active; v++) send(1'b1, 16'(v));
        readout(1'b0, -1);

        // Ramp 0..499 is dropped, block starts at 500.
        start_capture();
        for (int v = 0; v < 500; v++) send(1'b1, 16'(v));
        check("trig_pre_wc", 32'(wr_count), 32'd0);
        check("trig_pre_busy", 32'(busy), 32'd1);
        send(1'b1, 16'd500);
        check("trig_500_wc", 32'(wr_count), 32'd1);
        for (int v = 501; m_active; v++) send(1'b1, 16'(v));
        readout(1'b0, -1);

        // Most negative sample has magnitude 32768.
        trig_level = 16'h8000;
        m_level    = 32768;
        start_capture();
        send(1'b1, 16'h7FFF);
        check("trig_max_pos_wc", 32'(wr_count), 32'd0);
        send(1'b1, 16'h8000);
        check("trig_min_neg_wc", 32'(wr_count), 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        m_active = 1'b0;
        check("trig_abort_busy", 32'(busy), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
